// File: rtl/latch_write_arbiter_if.sv
// rtl/latch_write_arbiter_if.sv - requester and latch-bank signal bundle for latch_write_arbiter
interface latch_write_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       grant;
    logic               busy;
    logic               done;
    logic               lat_c;
    logic [WIDTH-1:0]   lat_d;

    modport master (
        output req,
        output wdata,
        input  grant,
        input  busy,
        input  done,
        input  lat_c,
        input  lat_d
    );

    modport slave (
        input  req,
        input  wdata,
        output grant,
        output busy,
        output done,
        output lat_c,
        output lat_d
    );
endinterface

// File: rtl/latch_write_arbiter.sv
// rtl/latch_write_arbiter.sv - arbitrated set-up/open/hold sequencer for a shared D latch bank
// Define LATCH_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module latch_write_arbiter #(
    parameter int N           = 4,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               clr,
    latch_write_arbiter_if.slave bus
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] dreg, dreg_nxt;
    logic [WIDTH-1:0] lat_d_q, lat_d_nxt;
    logic [N-1:0]     grant_q, grant_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             lat_c_q, lat_c_nxt;

    logic [IDXW-1:0]  win_idx;
    logic             win_found;
    logic [WIDTH-1:0] win_data;

`ifdef LATCH_ARB_RR_EN
    logic [IDXW-1:0]  ptr, ptr_nxt;
    int               rr_idx;

    // Search starts at the pointer and wraps modulo N, so N need not be a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int k = 0; k < N; k++) begin
            rr_idx = int'(ptr) + k;
            if (rr_idx >= N) begin
                rr_idx = rr_idx - N;
            end
            if (!win_found && bus.req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(rr_idx);
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (state == IDLE && win_found) begin
            ptr_nxt = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && bus.req[k]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(k);
            end
        end
    end
`endif

    assign win_data = bus.wdata[win_idx*WIDTH +: WIDTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dreg_nxt  = dreg;
        lat_d_nxt = lat_d_q;
        grant_nxt = grant_q;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt          = SETUP;
                    dreg_nxt           = win_data;
                    lat_d_nxt          = win_data;
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = OPEN;
                cnt_nxt   = CW'(OPEN_CYCLES - 1);
                lat_d_nxt = dreg;
            end
            OPEN: begin
                lat_d_nxt = dreg;
                if (cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
                lat_d_nxt = dreg;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        busy_nxt  = (state_nxt != IDLE);
        lat_c_nxt = (state_nxt == OPEN);
        done_nxt  = (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            dreg    <= '0;
            lat_d_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lat_c_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dreg    <= dreg_nxt;
            lat_d_q <= lat_d_nxt;
            grant_q <= grant_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            lat_c_q <= lat_c_nxt;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.lat_c = lat_c_q;
    assign bus.lat_d = lat_d_q;
endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb/tb_latch_write_arbiter.sv - directed self-checking bench for latch_write_arbiter
module tb_latch_write_arbiter;
    localparam int OC_A = 2;

    logic clk = 1'b0;
    logic clr;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    latch_write_arbiter_if #(.N(4), .WIDTH(8)) a_if ();
    latch_write_arbiter_if #(.N(2), .WIDTH(8)) b_if ();

    latch_write_arbiter #(.N(4), .WIDTH(8), .OPEN_CYCLES(OC_A)) dut_a (
        .clk(clk), .clr(clr), .bus(a_if)
    );
    latch_write_arbiter #(.N(2), .WIDTH(8), .OPEN_CYCLES(1)) dut_b (
        .clk(clk), .clr(clr), .bus(b_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle_zero(input string tag);
        chk({tag, "_grant"}, a_if.grant, 0);
        chk({tag, "_busy"},  a_if.busy,  0);
        chk({tag, "_done"},  a_if.done,  0);
        chk({tag, "_lat_c"}, a_if.lat_c, 0);
        chk({tag, "_lat_d"}, a_if.lat_d, 0);
    endtask

    // Entered in the SETUP cycle; leaves in the first IDLE cycle afterwards.
    task automatic a_txn(input string tag, input logic [3:0] eg, input logic [7:0] ed);
        chk({tag, "_su_grant"}, a_if.grant, eg);
        chk({tag, "_su_busy"},  a_if.busy,  1);
        chk({tag, "_su_lat_c"}, a_if.lat_c, 0);
        chk({tag, "_su_lat_d"}, a_if.lat_d, ed);
        for (int i = 0; i < OC_A; i++) begin
            tick();
            chk({tag, "_op_lat_c"}, a_if.lat_c, 1);
            chk({tag, "_op_done"},  a_if.done,  0);
            chk({tag, "_op_lat_d"}, a_if.lat_d, ed);
        end
        tick();
        chk({tag, "_hd_lat_c"}, a_if.lat_c, 0);
        chk({tag, "_hd_done"},  a_if.done,  1);
        chk({tag, "_hd_grant"}, a_if.grant, eg);
        chk({tag, "_hd_lat_d"}, a_if.lat_d, ed);
        tick();
        chk({tag, "_id_busy"},  a_if.busy,  0);
        chk({tag, "_id_done"},  a_if.done,  0);
        chk({tag, "_id_grant"}, a_if.grant, 0);
        chk({tag, "_id_lat_d"}, a_if.lat_d, ed);
    endtask

    task automatic b_txn(input string tag, input logic [1:0] eg, input logic [7:0] ed);
        chk({tag, "_su_grant"}, b_if.grant, eg);
        chk({tag, "_su_busy"},  b_if.busy,  1);
        chk({tag, "_su_lat_c"}, b_if.lat_c, 0);
        chk({tag, "_su_lat_d"}, b_if.lat_d, ed);
        tick();
        chk({tag, "_op_lat_c"}, b_if.lat_c, 1);
        chk({tag, "_op_busy"},  b_if.busy,  1);
        tick();
        chk({tag, "_hd_lat_c"}, b_if.lat_c, 0);
        chk({tag, "_hd_done"},  b_if.done,  1);
        chk({tag, "_hd_busy"},  b_if.busy,  1);
        tick();
        chk({tag, "_id_busy"},  b_if.busy,  0);
        chk({tag, "_id_grant"}, b_if.grant, 0);
    endtask

    initial begin
        clr      = 1'b1;
        a_if.req = 4'b1111;
        a_if.wdata = {8'h77, 8'hA5, 8'h3C, 8'h11};
        b_if.req = 2'b00;
        b_if.wdata = {8'hC3, 8'h5A};

        // Reset held with requests pending
        tick();
        a_idle_zero("rst1");
        tick();
        a_idle_zero("rst2");
        clr = 1'b0;
        tick();
        a_if.req = 4'b0000;
        a_txn("first", 4'b0001, 8'h11);

        // Single write
        a_if.req = 4'b0100;
        tick();
        a_if.req = 4'b0000;
        a_txn("single", 4'b0100, 8'hA5);

        // Contention from a freshly reset pointer
        clr = 1'b1;
        tick();
        a_idle_zero("rst3");
        clr = 1'b0;
        a_if.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [3:0] eg;
            logic [7:0] ed;
`ifdef LATCH_ARB_RR_EN
            eg = 4'b0001 << (t % 4);
`else
            eg = 4'b0001;
`endif
            case (eg)
                4'b0001: ed = 8'h11;
                4'b0010: ed = 8'h3C;
                4'b0100: ed = 8'hA5;
                default: ed = 8'h77;
            endcase
            tick();
            if (t == 4) a_if.req = 4'b0000;
            a_txn($sformatf("cont%0d", t), eg, ed);
        end

        // Data and request change during OPEN
        a_if.req = 4'b0010;
        tick();
        chk("mid_su_grant", a_if.grant, 4'b0010);
        chk("mid_su_lat_d", a_if.lat_d, 8'h3C);
        tick();
        chk("mid_op1_lat_c", a_if.lat_c, 1);
        a_if.wdata[15:8] = 8'hFF;
        a_if.req = 4'b0000;
        tick();
        chk("mid_op2_lat_c", a_if.lat_c, 1);
        chk("mid_op2_lat_d", a_if.lat_d, 8'h3C);
        tick();
        chk("mid_hd_done",  a_if.done,  1);
        chk("mid_hd_lat_d", a_if.lat_d, 8'h3C);
        tick();
        chk("mid_id_busy", a_if.busy, 0);
        tick();
        chk("mid_id2_busy",  a_if.busy,  0);
        chk("mid_id2_grant", a_if.grant, 0);
        chk("mid_id2_lat_d", a_if.lat_d, 8'h3C);

        // Reset in the first OPEN cycle
        a_if.req = 4'b0100;
        tick();
        chk("rmid_su_grant", a_if.grant, 4'b0100);
        tick();
        chk("rmid_op_lat_c", a_if.lat_c, 1);
        clr = 1'b1;
        a_if.req = 4'b1010;
        tick();
        a_idle_zero("rmid");
        clr = 1'b0;
        tick();
        a_if.req = 4'b0000;
        a_txn("rmid_after", 4'b0010, 8'hFF);

        // Two requesters, one open cycle
        b_if.req = 2'b10;
        tick();
        b_if.req = 2'b00;
        b_txn("b_single", 2'b10, 8'hC3);
        b_if.req = 2'b11;
        tick();
        b_txn("b_wrap", 2'b01, 8'h5A);
        tick();
        b_if.req = 2'b00;
`ifdef LATCH_ARB_RR_EN
        b_txn("b_next", 2'b10, 8'hC3);
`else
        b_txn("b_next", 2'b01, 8'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Sequencer and arbiter sharing one level-sensitive D latch bank (gate `c`, data `d`) among N requesters. It grants one requester at a time and captures that requester's write data. It then drives the latch through a fixed set-up / open / hold sequence, so `d` never changes while `c` is high or on the edge where `c` falls. It sits between requesting units and the latch bank and is the only driver of the bank's `c` and `d` inputs.

## Interface
- `N`, 4: number of requesters (2..8)
- `WIDTH`, 8: latch bank data width
- `OPEN_CYCLES`, 2: cycles `lat_c` is held high per write (>=1)
- `clk` in 1: clock; all state changes on rising edge
- `clr` in 1: reset, synchronous, active-high
- `req` in N: write request, one bit per requester, level
- `wdata` in N*WIDTH: write data; slot i = `wdata[i*WIDTH +: WIDTH]`
- `grant` out N: one-hot, identifies the requester being served
- `busy` out 1: transaction in progress (state != IDLE)
- `done` out 1: one-cycle pulse, latch write complete
- `lat_c` out 1: latch gate (`c`) to latch bank
- `lat_d` out WIDTH: latch data (`d`) to latch bank

## Operation
- All outputs are registered.
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE:
  - If `req` != 0, select a winner, latch the winner's `wdata` slot into `dreg`, set `grant`, and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: `lat_c`=0, `lat_d`=`dreg`. Go to OPEN and load the open counter with OPEN_CYCLES-1.
- OPEN: `lat_c`=1, `lat_d`=`dreg`. Counter decrements each cycle; on 0, go to HOLD.
- HOLD: `lat_c`=0, `lat_d`=`dreg`, `done`=1. Go to IDLE.
- `grant` is held from SETUP through HOLD and is 0 in IDLE.
- `busy`=1 in SETUP, OPEN and HOLD.
- `lat_d` keeps its last value in IDLE.
- Write data is captured once, at grant. Changes on `wdata` after that are ignored.
- `req` is sampled only in IDLE:
  - Dropping `req` mid-transaction does not abort the write.
  - A requester that is still high after HOLD re-competes in the next IDLE cycle.
- Winner selection: see Configuration.
- `clr`=1 at an edge, in any state, takes effect on that edge:
  - state=IDLE
  - `lat_c`=0, `grant`=0, `done`=0, `busy`=0, `lat_d`=0, `dreg`=0, counter=0
  - round-robin pointer=0
- A reset during OPEN therefore truncates the latch pulse. The bank keeps whatever value it had when `c` fell.

## Timing
- Reset values: `lat_c`=0, `lat_d`=0, `grant`=0, `busy`=0, `done`=0.
- `req` seen high at edge k while in IDLE gives `grant`/`busy` high after edge k. That cycle is SETUP.
- `lat_c` is high for exactly OPEN_CYCLES cycles, starting one cycle after `grant` rises.
- `done` is high for the one cycle after `lat_c` falls. `grant` falls with `done`.
- Transaction length: OPEN_CYCLES+2 cycles busy, plus at least 1 IDLE cycle between transactions. Back-to-back writes therefore repeat every OPEN_CYCLES+3 cycles.
- Invariants:
  - `lat_d` is stable in the cycle before `lat_c` rises, throughout OPEN, and in the cycle after `lat_c` falls.
  - `lat_c` and `done` are never high together.

## Configuration
- `LATCH_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer holds the highest-priority index.
  - Search order is pointer, pointer+1, ... wrapping modulo N.
  - After a grant to index g, the pointer becomes (g+1) mod N.
  - The pointer resets to 0.
- `LATCH_ARB_RR_EN` undefined: fixed priority, lowest asserted index wins. No pointer register is built.

## Test plan
- Reset: `clr`=1 for 2 cycles with `req`=4'b1111 → all outputs 0 during and immediately after reset. After release, first grant=4'b0001.
- Single write: `req`=4'b0100, slot 2=8'hA5 → next cycle `grant`=4'b0100, `lat_d`=8'hA5, `lat_c`=0 for 1 cycle, then 1 for 2 cycles, then 0 with `done`=1, then IDLE. `lat_d` stays 8'hA5 throughout.
- Contention, `req`=4'b1111 held: with `LATCH_ARB_RR_EN`, grants are 0001, 0010, 0100, 1000, 0001, each 5 cycles apart. Without it, grant is 0001 every transaction.
- Data/req change mid-write: slot 1 changes 8'h3C→8'hFF during OPEN and `req[1]` drops in OPEN → `lat_d` stays 8'h3C, `done` still pulses, no further grant.
- Reset mid-operation: `clr`=1 in first OPEN cycle → next cycle `lat_c`=0, `grant`=0, `busy`=0, `lat_d`=0. With RR and `req`=4'b1010 afterwards, grant=4'b0010 first.
- Boundary: OPEN_CYCLES=1, N=2 → `lat_c` high exactly 1 cycle. Busy lasts 3 cycles. The RR pointer wraps 1→0.
